transpose_chunk_scheduler: RTL and testbench

//  Sequences a full ARR_SIZE x ARR_SIZE matrix transpose job through the transpose datapath, one CHUNK_SIZE x CHUNK_SIZE tile at a time.
//  - Walks the chunk grid and issues tile read requests to the memory reader.
//  - Drives in_val, ctrl, base_addr and chunk_addr into the transpose unit in step with returning tile data.
//  - Bounds the number of tiles in flight with a credit counter.
//  - Counts out_val completions and signals job done.

---
 rtl/transpose_chunk_scheduler.sv | 202 ++++++++++++++++++++
 tb/tb_transpose_chunk_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/transpose_chunk_scheduler.sv
// Tile scheduler for a full-matrix transpose job: walks the chunk grid, issues
// tile reads, feeds the transpose unit and bounds outstanding tiles with credits.
module transpose_chunk_scheduler #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 64,
  parameter int ARR_SIZE     = 16,
  parameter int CHUNK_SIZE   = 8,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr_i,
  input  logic                  cfg_mode_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  rd_req_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  input  logic                  rd_gnt_i,
  input  logic                  rd_data_val_i,
  output logic                  mt_in_val_o,
  output logic                  mt_ctrl_o,
  output logic [ADDR_WIDTH-1:0] mt_base_addr_o,
  output logic [ADDR_WIDTH-1:0] mt_chunk_addr_o,
  input  logic                  mt_out_val_i
);

  localparam int ELEM_BYTES = DATA_WIDTH / 8;
  localparam int NCH        = ARR_SIZE / CHUNK_SIZE;
  localparam int TOTAL      = NCH * NCH;
  localparam int PW         = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW         = $clog2(TOTAL + 1);
  localparam int IW         = $clog2(MAX_INFLIGHT + 1);
  localparam int ROW_STRIDE = ARR_SIZE * CHUNK_SIZE * ELEM_BYTES;
  localparam int COL_STRIDE = CHUNK_SIZE * ELEM_BYTES;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic                  mode_q, mode_d;
  logic [PW-1:0]         rq_r_q, rq_r_d, rq_c_q, rq_c_d;
  logic [PW-1:0]         dt_r_q, dt_r_d, dt_c_q, dt_c_d;
  logic [CW-1:0]         iss_cnt_q, iss_cnt_d, dt_cnt_q, dt_cnt_d, cmp_cnt_q, cmp_cnt_d;
  logic [IW-1:0]         inflight_q, inflight_d;
  logic                  busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                  rd_req_q, rd_req_d, mt_in_val_q, mt_in_val_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d, mt_chunk_addr_q, mt_chunk_addr_d;

  logic gnt_s, idle_s, ret_ok_s, dat_ok_s, err_ev_s;

  function automatic logic [ADDR_WIDTH-1:0] tile_addr(input logic [ADDR_WIDTH-1:0] base,
                                                      input logic [PW-1:0] r,
                                                      input logic [PW-1:0] c);
    tile_addr = base + ADDR_WIDTH'(r) * ADDR_WIDTH'(ROW_STRIDE)
                     + ADDR_WIDTH'(c) * ADDR_WIDTH'(COL_STRIDE);
  endfunction

  // Illegal returns/data are flagged but never allowed to move the counters.
  assign gnt_s    = rd_req_q & rd_gnt_i;
  assign idle_s   = (state_q == S_IDLE);
  assign ret_ok_s = mt_out_val_i & ~idle_s & (inflight_q != '0);
  assign dat_ok_s = rd_data_val_i & ~idle_s & (iss_cnt_q != dt_cnt_q);
  assign err_ev_s = (mt_out_val_i & ~ret_ok_s) | (rd_data_val_i & ~dat_ok_s);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      base_q          <= '0;
      mode_q          <= 1'b0;
      rq_r_q          <= '0;
      rq_c_q          <= '0;
      dt_r_q          <= '0;
      dt_c_q          <= '0;
      iss_cnt_q       <= '0;
      dt_cnt_q        <= '0;
      cmp_cnt_q       <= '0;
      inflight_q      <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
      rd_req_q        <= 1'b0;
      rd_addr_q       <= '0;
      mt_in_val_q     <= 1'b0;
      mt_chunk_addr_q <= '0;
    end else begin
      state_q         <= state_d;
      base_q          <= base_d;
      mode_q          <= mode_d;
      rq_r_q          <= rq_r_d;
      rq_c_q          <= rq_c_d;
      dt_r_q          <= dt_r_d;
      dt_c_q          <= dt_c_d;
      iss_cnt_q       <= iss_cnt_d;
      dt_cnt_q        <= dt_cnt_d;
      cmp_cnt_q       <= cmp_cnt_d;
      inflight_q      <= inflight_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      err_q           <= err_d;
      rd_req_q        <= rd_req_d;
      rd_addr_q       <= rd_addr_d;
      mt_in_val_q     <= mt_in_val_d;
      mt_chunk_addr_q <= mt_chunk_addr_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    base_d          = base_q;
    mode_d          = mode_q;
    rq_r_d          = rq_r_q;
    rq_c_d          = rq_c_q;
    dt_r_d          = dt_r_q;
    dt_c_d          = dt_c_q;
    iss_cnt_d       = iss_cnt_q;
    dt_cnt_d        = dt_cnt_q;
    err_d           = err_q | err_ev_s;
    inflight_d      = inflight_q + IW'(gnt_s) - IW'(ret_ok_s);
    cmp_cnt_d       = cmp_cnt_q + CW'(ret_ok_s);
    mt_in_val_d     = dat_ok_s;
    mt_chunk_addr_d = dat_ok_s ? tile_addr(base_q, dt_r_q, dt_c_q) : mt_chunk_addr_q;

    if (gnt_s) begin
      iss_cnt_d = iss_cnt_q + CW'(1);
      if (rq_c_q == PW'(NCH - 1)) begin
        rq_c_d = '0;
        rq_r_d = rq_r_q + PW'(1);
      end else begin
        rq_c_d = rq_c_q + PW'(1);
      end
    end else begin
      iss_cnt_d = iss_cnt_q;
    end

    if (dat_ok_s) begin
      dt_cnt_d = dt_cnt_q + CW'(1);
      if (dt_c_q == PW'(NCH - 1)) begin
        dt_c_d = '0;
        dt_r_d = dt_r_q + PW'(1);
      end else begin
        dt_c_d = dt_c_q + PW'(1);
      end
    end else begin
      dt_cnt_d = dt_cnt_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d    = S_ISSUE;
          base_d     = cfg_base_addr_i;
          mode_d     = cfg_mode_i;
          rq_r_d     = '0;
          rq_c_d     = '0;
          dt_r_d     = '0;
          dt_c_d     = '0;
          iss_cnt_d  = '0;
          dt_cnt_d   = '0;
          cmp_cnt_d  = '0;
          inflight_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (gnt_s && (iss_cnt_q == CW'(TOTAL - 1))) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (cmp_cnt_q == CW'(TOTAL)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from next-state values so they line up with the FSM.
    busy_d    = (state_d == S_ISSUE) || (state_d == S_DRAIN);
    done_d    = (state_d == S_DONE);
    rd_req_d  = (state_d == S_ISSUE) && (inflight_d < IW'(MAX_INFLIGHT));
    rd_addr_d = (state_d == S_ISSUE) ? tile_addr(base_d, rq_r_d, rq_c_d) : rd_addr_q;
  end

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign err_o           = err_q;
  assign rd_req_o        = rd_req_q;
  assign rd_addr_o       = rd_addr_q;
  assign mt_in_val_o     = mt_in_val_q;
  assign mt_ctrl_o       = mode_q;
  assign mt_base_addr_o  = base_q;
  assign mt_chunk_addr_o = mt_chunk_addr_q;

endmodule

// File: tb/tb_transpose_chunk_scheduler.sv
// Self-checking bench for transpose_chunk_scheduler: directed jobs plus randomized
// jobs, compared against tile addresses computed from the grid arithmetic.
module tb_transpose_chunk_scheduler;

  localparam int DW    = 64;
  localparam int AW    = 64;
  localparam int ARR   = 16;
  localparam int CH    = 8;
  localparam int MAXI  = 2;
  localparam int NCH   = ARR / CH;
  localparam int TOTAL = NCH * NCH;

  logic          clk = 1'b0;
  logic          rst, start_i, cfg_mode_i, rd_gnt_i, rd_data_val_i, mt_out_val_i;
  logic [AW-1:0] cfg_base_addr_i;
  logic          busy_o, done_o, err_o, rd_req_o, mt_in_val_o, mt_ctrl_o;
  logic [AW-1:0] rd_addr_o, mt_base_addr_o, mt_chunk_addr_o;

  always #5 clk = ~clk;

  transpose_chunk_scheduler #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ARR_SIZE(ARR), .CHUNK_SIZE(CH), .MAX_INFLIGHT(MAXI)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .cfg_base_addr_i(cfg_base_addr_i),
    .cfg_mode_i(cfg_mode_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .rd_req_o(rd_req_o), .rd_addr_o(rd_addr_o), .rd_gnt_i(rd_gnt_i),
    .rd_data_val_i(rd_data_val_i), .mt_in_val_o(mt_in_val_o), .mt_ctrl_o(mt_ctrl_o),
    .mt_base_addr_o(mt_base_addr_o), .mt_chunk_addr_o(mt_chunk_addr_o),
    .mt_out_val_i(mt_out_val_i)
  );

  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  int            gnt_mode = 0;
  bit            ret_en, force_ret, rand_lat, inj_ret, inj_data;
  int            data_due[$];
  int            ret_due[$];
  logic [AW-1:0] got_rd[$];
  logic [AW-1:0] got_mt[$];
  int            n_done, n_ret, ret_at_done;
  logic [AW-1:0] basic_tbl [TOTAL];

  // Reference: tile k in row-major order, byte offset from the grid geometry.
  function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] base, input int k);
    int r, c;
    r = k / NCH;
    c = k % NCH;
    return base + AW'(r * ARR * CH + c * CH) * AW'(DW / 8);
  endfunction

  task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive the environment's inputs, clock, then observe the DUT.
  task automatic step();
    int            c, due;
    logic          pre_req;
    logic [AW-1:0] pre_addr;
    c        = cyc;
    pre_req  = rd_req_o;
    pre_addr = rd_addr_o;
    rd_data_val_i = inj_data;
    if (data_due.size() > 0 && data_due[0] <= c) begin
      rd_data_val_i = 1'b1;
      void'(data_due.pop_front());
    end
    mt_out_val_i = inj_ret;
    if (ret_due.size() > 0 && (force_ret || (ret_en && ret_due[0] <= c))) begin
      mt_out_val_i = 1'b1;
      void'(ret_due.pop_front());
    end
    force_ret = 1'b0;
    case (gnt_mode)
      0:       rd_gnt_i = 1'b0;
      1:       rd_gnt_i = 1'b1;
      default: rd_gnt_i = 1'($urandom_range(0, 1));
    endcase
    @(posedge clk);
    #1;
    cyc++;
    if (pre_req && rd_gnt_i) begin
      got_rd.push_back(pre_addr);
      due = c + (rand_lat ? int'($urandom_range(1, 4)) : 2);
      if (data_due.size() > 0 && due <= data_due[$]) due = data_due[$] + 1;
      data_due.push_back(due);
    end
    if (mt_in_val_o) begin
      got_mt.push_back(mt_chunk_addr_o);
      due = c + 1 + (rand_lat ? int'($urandom_range(1, 12)) : 9);
      if (ret_due.size() > 0 && due <= ret_due[$]) due = ret_due[$] + 1;
      ret_due.push_back(due);
    end
    if (mt_out_val_i) n_ret++;
    if (done_o) begin
      n_done++;
      ret_at_done = n_ret;
    end
  endtask

  task automatic clear_env();
    data_due.delete();
    ret_due.delete();
    got_rd.delete();
    got_mt.delete();
    n_done = 0; n_ret = 0; ret_at_done = 0;
    force_ret = 1'b0; inj_ret = 1'b0; inj_data = 1'b0;
    rd_gnt_i = 1'b0; rd_data_val_i = 1'b0; mt_out_val_i = 1'b0; start_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_env();
    gnt_mode = 0;
    repeat (3) step();
    rst = 1'b0;
    clear_env();
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy_o), 64'd0);
    chk({tag, "_done"}, 64'(done_o), 64'd0);
    chk({tag, "_rd_req"}, 64'(rd_req_o), 64'd0);
    chk({tag, "_rd_addr"}, rd_addr_o, 64'd0);
    chk({tag, "_in_val"}, 64'(mt_in_val_o), 64'd0);
    chk({tag, "_ctrl"}, 64'(mt_ctrl_o), 64'd0);
    chk({tag, "_base"}, mt_base_addr_o, 64'd0);
    chk({tag, "_chunk"}, mt_chunk_addr_o, 64'd0);
  endtask

  task automatic start_job(input string tag, input logic [AW-1:0] base, input logic mode);
    got_rd.delete(); got_mt.delete();
    n_done = 0; n_ret = 0; ret_at_done = 0; ret_en = 1'b0;
    cfg_base_addr_i = base;
    cfg_mode_i      = mode;
    start_i         = 1'b1;
    step();
    start_i         = 1'b0;
    chk({tag, "_busy_up"}, 64'(busy_o), 64'd1);
    chk({tag, "_req_up"}, 64'(rd_req_o), 64'd1);
    chk({tag, "_first_addr"}, rd_addr_o, base);
    chk({tag, "_mt_base"}, mt_base_addr_o, base);
    chk({tag, "_mt_ctrl"}, 64'(mt_ctrl_o), 64'(mode));
  endtask

  task automatic finish_job(input string tag, input logic [AW-1:0] base, input logic exp_err);
    ret_en = 1'b1;
    for (int i = 0; i < 2000 && n_done == 0; i++) step();
    repeat (3) step();
    chk({tag, "_done_pulses"}, 64'(n_done), 64'd1);
    chk({tag, "_ret_at_done"}, 64'(ret_at_done), 64'(TOTAL));
    chk({tag, "_busy_end"}, 64'(busy_o), 64'd0);
    chk({tag, "_req_end"}, 64'(rd_req_o), 64'd0);
    chk({tag, "_err"}, 64'(err_o), 64'(exp_err));
    chk({tag, "_n_rd"}, 64'(got_rd.size()), 64'(TOTAL));
    chk({tag, "_n_mt"}, 64'(got_mt.size()), 64'(TOTAL));
    for (int k = 0; k < got_rd.size(); k++) chk({tag, "_rd_addr"}, got_rd[k], exp_addr(base, k));
    for (int k = 0; k < got_mt.size(); k++) chk({tag, "_mt_addr"}, got_mt[k], exp_addr(base, k));
  endtask

  initial begin
    basic_tbl[0] = 64'h1000;
    basic_tbl[1] = 64'h1040;
    basic_tbl[2] = 64'h1400;
    basic_tbl[3] = 64'h1440;
    cfg_base_addr_i = '0;
    cfg_mode_i = 1'b0;
    rand_lat = 1'b0;
    ret_en = 1'b0;

    // Reset state
    do_reset();
    check_idle_outputs("reset");
    chk("reset_err", 64'(err_o), 64'd0);

    // Reset in the middle of ISSUE abandons the job
    gnt_mode = 1;
    start_job("mid", 64'h1000, 1'b1);
    repeat (2) step();
    do_reset();
    check_idle_outputs("mid_rst");
    chk("mid_rst_done", 64'(n_done), 64'd0);
    repeat (4) step();
    chk("mid_rst_quiet", 64'(busy_o), 64'd0);
    gnt_mode = 1;
    start_job("after_rst", 64'h1000, 1'b0);
    finish_job("after_rst", 64'h1000, 1'b0);

    // Basic job, constant address table
    gnt_mode = 1;
    start_job("basic", 64'h1000, 1'b1);
    finish_job("basic", 64'h1000, 1'b0);
    for (int k = 0; k < got_rd.size() && k < TOTAL; k++) chk("basic_rd_tbl", got_rd[k], basic_tbl[k]);
    for (int k = 0; k < got_mt.size() && k < TOTAL; k++) chk("basic_mt_tbl", got_mt[k], basic_tbl[k]);

    // Backpressure on tile 1
    gnt_mode = 0;
    start_job("bp", 64'h1000, 1'b0);
    gnt_mode = 1;
    step();
    gnt_mode = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_req_held", 64'(rd_req_o), 64'd1);
      chk("bp_addr_held", rd_addr_o, 64'h1040);
    end
    chk("bp_grants", 64'(got_rd.size()), 64'd1);
    gnt_mode = 1;
    finish_job("bp", 64'h1000, 1'b0);

    // Credit limit with returns withheld
    gnt_mode = 1;
    start_job("cred", 64'h1000, 1'b0);
    repeat (8) step();
    chk("cred_grants2", 64'(got_rd.size()), 64'(MAXI));
    chk("cred_req_low", 64'(rd_req_o), 64'd0);
    force_ret = 1'b1;
    step();
    repeat (6) step();
    chk("cred_one_more", 64'(got_rd.size()), 64'(MAXI + 1));
    chk("cred_req_low2", 64'(rd_req_o), 64'd0);
    finish_job("cred", 64'h1000, 1'b0);

    // Simultaneous grant and credit return keeps the credit count unchanged
    gnt_mode = 1;
    start_job("simul", 64'h2000, 1'b1);
    step();
    gnt_mode = 0;
    repeat (4) step();
    chk("simul_pending", 64'(ret_due.size()), 64'd1);
    gnt_mode  = 1;
    force_ret = 1'b1;
    step();
    chk("simul_req_kept", 64'(rd_req_o), 64'd1);
    chk("simul_grants", 64'(got_rd.size()), 64'd2);
    step();
    chk("simul_req_drop", 64'(rd_req_o), 64'd0);
    chk("simul_grants3", 64'(got_rd.size()), 64'd3);
    finish_job("simul", 64'h2000, 1'b0);

    // start while busy is ignored
    gnt_mode = 1;
    start_job("rest", 64'h1000, 1'b0);
    repeat (3) step();
    cfg_base_addr_i = 64'h9000;
    cfg_mode_i      = 1'b1;
    start_i         = 1'b1;
    repeat (2) step();
    start_i         = 1'b0;
    chk("rest_base", mt_base_addr_o, 64'h1000);
    chk("rest_ctrl", 64'(mt_ctrl_o), 64'd0);
    finish_job("rest", 64'h1000, 1'b0);

    // Randomized jobs, including an address wrap-around
    rand_lat = 1'b1;
    for (int j = 0; j < 4; j++) begin
      logic [AW-1:0] b;
      logic          m;
      b = (j == 0) ? 64'hFFFF_FFFF_FFFF_FC00 : {$urandom, $urandom};
      m = 1'($urandom_range(0, 1));
      gnt_mode = 2;
      start_job("rnd", b, m);
      finish_job("rnd", b, 1'b0);
    end
    rand_lat = 1'b0;

    // Spurious out_val in IDLE sets sticky err without counting
    do_reset();
    inj_ret = 1'b1;
    step();
    inj_ret = 1'b0;
    chk("idle_ret_err", 64'(err_o), 64'd1);
    repeat (4) step();
    chk("idle_ret_sticky", 64'(err_o), 64'd1);
    chk("idle_ret_busy", 64'(busy_o), 64'd0);
    gnt_mode = 1;
    start_job("err_job", 64'h3000, 1'b0);
    finish_job("err_job", 64'h3000, 1'b1);
    do_reset();
    chk("err_cleared", 64'(err_o), 64'd0);

    // Spurious data in IDLE
    inj_data = 1'b1;
    step();
    inj_data = 1'b0;
    chk("idle_data_err", 64'(err_o), 64'd1);
    chk("idle_data_inval", 64'(mt_in_val_o), 64'd0);
    do_reset();
    chk("err_cleared2", 64'(err_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
